// File: rtl/apb_rr_master.sv
// APB master shared by NREQ requesters with a round-robin arbiter.
// Each transfer is one SETUP and one ACCESS cycle; the next request may be accepted during ACCESS.
module apb_rr_master #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic               apb_pclk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic [31:0]        apb_paddr,
  output logic               apb_psel,
  output logic               apb_penable,
  output logic               apb_pwrite,
  output logic [31:0]        apb_pwdata,
  input  logic [31:0]        apb_prdata
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam logic [31:0] AddrMask =
      (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_WIDTH) - 32'd1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   last_grant_q;
  logic [IdxW-1:0]   idx_q;

  logic              found;
  logic [IdxW-1:0]   win;
  logic [31:0]       win_addr;
  logic [31:0]       win_wdata;
  logic              win_write;
  logic              can_accept;
  logic              accept;

  // Two passes: requesters above last_grant first, then wrap to the rest.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!found && (j > int'(last_grant_q)) && req_valid[j]) begin
        found     = 1'b1;
        win       = IdxW'(j);
        win_addr  = req_addr[j*32 +: 32];
        win_wdata = req_wdata[j*32 +: 32];
        win_write = req_write[j];
      end
    end
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!found && (j <= int'(last_grant_q)) && req_valid[j]) begin
        found     = 1'b1;
        win       = IdxW'(j);
        win_addr  = req_addr[j*32 +: 32];
        win_wdata = req_wdata[j*32 +: 32];
        win_write = req_write[j];
      end
    end
  end

  always_comb begin
    can_accept = rst && ((state_q == StIdle) || (state_q == StAccess));
    accept     = can_accept && found;
    req_ready  = accept ? (NREQ'(1) << win) : '0;
  end

  always_ff @(posedge apb_pclk) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NREQ - 1);
      idx_q        <= '0;
      apb_psel     <= 1'b0;
      apb_penable  <= 1'b0;
      apb_pwrite   <= 1'b0;
      apb_paddr    <= '0;
      apb_pwdata   <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
    end else begin
      rsp_valid <= '0;
      // apb_pwrite still describes the transfer that is finishing here.
      if (state_q == StAccess) begin
        rsp_valid <= NREQ'(1) << idx_q;
        rsp_rdata <= apb_pwrite ? 32'd0 : apb_prdata;
      end
      unique case (state_q)
        StIdle, StAccess: begin
          if (accept) begin
            state_q      <= StSetup;
            idx_q        <= win;
            last_grant_q <= win;
            apb_psel     <= 1'b1;
            apb_penable  <= 1'b0;
            apb_pwrite   <= win_write;
            apb_paddr    <= win_addr & AddrMask;
            apb_pwdata   <= win_wdata;
          end else begin
            state_q     <= StIdle;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
          end
        end
        StSetup: begin
          state_q     <= StAccess;
          apb_penable <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          apb_psel    <= 1'b0;
          apb_penable <= 1'b0;
          apb_pwrite  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: transaction-level model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional resets.
module tb_apb_rr_master;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam logic [31:0] MASK = 32'h0000_FFFF;

  logic            apb_pclk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_rdata;
  logic [31:0]     apb_paddr;
  logic            apb_psel;
  logic            apb_penable;
  logic            apb_pwrite;
  logic [31:0]     apb_pwdata;
  logic [31:0]     apb_prdata;

  always #5 apb_pclk = ~apb_pclk;

  apb_rr_master #(.NREQ(N), .ADDR_WIDTH(AW)) dut (
    .apb_pclk   (apb_pclk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .apb_paddr  (apb_paddr),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pwrite (apb_pwrite),
    .apb_pwdata (apb_pwdata),
    .apb_prdata (apb_prdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction model: phase 0 = bus free, 1 = first bus cycle, 2 = second bus cycle.
  bit           m_known = 1'b0;
  int           m_phase = 0;
  int           m_last  = N - 1;
  int           m_idx   = 0;
  bit           m_wr    = 1'b0;
  logic [31:0]  m_paddr = '0;
  logic [31:0]  m_pwdata = '0;
  logic [31:0]  m_rdata = '0;
  logic [N-1:0] m_rsp = '0;

  int cont_exp [8] = '{1, 0, 2, 0, 1, 0, 2, 0};
  int fair_ord [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    if (!rst || !m_known || m_phase == 1) return -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (((req_valid >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic cyc_begin();
    int w;
    @(negedge apb_pclk);
    if (m_known) begin
      w = model_winner();
      chk("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
      chk("apb_psel", 32'(apb_psel), 32'(m_phase != 0));
      chk("apb_penable", 32'(apb_penable), 32'(m_phase == 2));
      chk("apb_pwrite", 32'(apb_pwrite), 32'((m_phase != 0) && m_wr));
      chk("apb_paddr", apb_paddr, m_paddr);
      chk("apb_pwdata", apb_pwdata, m_pwdata);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      chk("rsp_rdata", rsp_rdata, m_rdata);
    end
  endtask

  task automatic cyc_end();
    int w;
    w = model_winner();
    if (!rst) begin
      m_known  = 1'b1;
      m_phase  = 0;
      m_last   = N - 1;
      m_wr     = 1'b0;
      m_paddr  = '0;
      m_pwdata = '0;
      m_rsp    = '0;
      m_rdata  = '0;
    end else if (m_known) begin
      m_rsp = '0;
      if (m_phase == 2) begin
        m_rsp   = N'(1) << m_idx;
        m_rdata = m_wr ? 32'd0 : apb_prdata;
      end
      if (w >= 0) begin
        m_idx    = w;
        m_last   = w;
        m_wr     = req_write[w];
        m_paddr  = req_addr[w*32 +: 32] & MASK;
        m_pwdata = req_wdata[w*32 +: 32];
        m_phase  = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
    @(posedge apb_pclk);
    #1;
    apb_prdata = $urandom;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i]         = wr;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = '0;
    repeat (n) begin
      cyc_begin();
      cyc_end();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc_begin();
    cyc_end();
    rst = 1'b1;
  endtask

  initial begin
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    apb_prdata = '0;
    rst        = 1'b0;
    repeat (2) begin
      cyc_begin();
      cyc_end();
    end
    chk("reset_psel", 32'(apb_psel), 32'd0);
    chk("reset_paddr", apb_paddr, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;

    // Single write; upper address bits must be masked off.
    set_req(0, 1'b1, 32'hABCD_0010, 32'hDEAD_BEEF);
    req_valid = 4'b0001;
    cyc_begin(); chk("wr_ready", 32'(req_ready), 32'h1); cyc_end();
    req_valid = '0;
    cyc_begin();
    chk("wr_setup_psel", 32'(apb_psel), 32'd1);
    chk("wr_setup_penable", 32'(apb_penable), 32'd0);
    chk("wr_setup_paddr", apb_paddr, 32'h0000_0010);
    chk("wr_setup_pwrite", 32'(apb_pwrite), 32'd1);
    chk("wr_setup_pwdata", apb_pwdata, 32'hDEAD_BEEF);
    cyc_end();
    cyc_begin(); chk("wr_access_penable", 32'(apb_penable), 32'd1); cyc_end();
    cyc_begin();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_done_psel", 32'(apb_psel), 32'd0);
    cyc_end();

    // Single read by requester 1.
    set_req(1, 1'b0, 32'h0000_0000, 32'h5555_5555);
    req_valid = 4'b0010;
    cyc_begin(); chk("rd_ready", 32'(req_ready), 32'h2); cyc_end();
    req_valid = '0;
    cyc_begin(); chk("rd_setup_pwrite", 32'(apb_pwrite), 32'd0); cyc_end();
    apb_prdata = 32'h0176_5A03;
    cyc_begin(); chk("rd_access_penable", 32'(apb_penable), 32'd1); cyc_end();
    cyc_begin();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rd_rsp_rdata", rsp_rdata, 32'h0176_5A03);
    cyc_end();

    // Contention between 0 and 1 from reset release.
    do_reset();
    set_req(0, 1'b1, 32'h0000_0100, 32'h1111_1111);
    set_req(1, 1'b0, 32'h0000_0200, 32'h2222_2222);
    req_valid = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      cyc_begin();
      chk("cont_ready", 32'(req_ready), 32'(cont_exp[c]));
      if (c > 0) begin
        chk("cont_psel", 32'(apb_psel), 32'd1);
        chk("cont_penable", 32'(apb_penable), 32'((c % 2) == 0));
      end
      cyc_end();
    end
    idle_cycles(3);

    // Fairness across four requesters, then a lone requester winning repeatedly.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i[0], 32'h40 + 32'(i), 32'hA000_0000 + 32'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc_begin(); chk("fair_ready", 32'(req_ready), 32'd1 << fair_ord[k]); cyc_end();
      cyc_begin(); chk("fair_setup_ready", 32'(req_ready), 32'd0); cyc_end();
    end
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      cyc_begin(); chk("solo_ready", 32'(req_ready), 32'h4); cyc_end();
      cyc_begin(); cyc_end();
    end
    idle_cycles(3);

    // Reset during ACCESS of requester 1 aborts it silently.
    do_reset();
    req_valid = 4'b0010;
    cyc_begin(); chk("abort_ready", 32'(req_ready), 32'h2); cyc_end();
    req_valid = '0;
    cyc_begin(); cyc_end();
    rst = 1'b0;
    cyc_begin(); chk("abort_access_penable", 32'(apb_penable), 32'd1); cyc_end();
    rst = 1'b1;
    req_valid = 4'b0011;
    cyc_begin();
    chk("abort_psel", 32'(apb_psel), 32'd0);
    chk("abort_penable", 32'(apb_penable), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_first_ready", 32'(req_ready), 32'h1);
    cyc_end();
    idle_cycles(4);

    // Request raised only during SETUP is never served.
    req_valid = 4'b0001;
    cyc_begin(); chk("wd_ready0", 32'(req_ready), 32'h1); cyc_end();
    req_valid = 4'b0010;
    cyc_begin(); chk("wd_setup_ready", 32'(req_ready), 32'd0); cyc_end();
    req_valid = '0;
    cyc_begin(); chk("wd_access_ready", 32'(req_ready), 32'd0); cyc_end();
    for (int c = 0; c < 3; c++) begin
      cyc_begin(); chk("wd_no_transfer", 32'(apb_psel), 32'd0); cyc_end();
    end

    // Randomized traffic with occasional resets and withdrawn requests.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      req_valid = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15) | 4'b0101);
      for (int i = 0; i < N; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      cyc_begin();
      cyc_end();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
